// File: rtl/adder_arbiter_if.sv
// Port bundle for adder_arbiter: two requester ports, the shared full_adder hookup and the response port.
// A handshake completes on a rising edge where valid and ready are both high. A requester may drop valid
// before that edge. The response side holds its payload while valid is high until ready is seen.
interface adder_arbiter_if;
   logic       req0_valid;
   logic [3:0] req0_a;
   logic [3:0] req0_b;
   logic       req0_ready;
   logic       req1_valid;
   logic [3:0] req1_a;
   logic [3:0] req1_b;
   logic       req1_ready;
   logic [3:0] fa_a;
   logic [3:0] fa_b;
   logic [7:0] fa_out;
   logic       fa_carry;
   logic       fa_zero;
   logic       fa_parity;
   logic       fa_sign;
   logic       fa_overflow;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [7:0] rsp_sum;
   logic [4:0] rsp_flags;

   modport slave (
      input  req0_valid, req0_a, req0_b,
      output req0_ready,
      input  req1_valid, req1_a, req1_b,
      output req1_ready,
      output fa_a, fa_b,
      input  fa_out, fa_carry, fa_zero, fa_parity, fa_sign, fa_overflow,
      output rsp_valid, rsp_id, rsp_sum, rsp_flags,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_a, req0_b,
      input  req0_ready,
      output req1_valid, req1_a, req1_b,
      input  req1_ready,
      input  fa_a, fa_b,
      output fa_out, fa_carry, fa_zero, fa_parity, fa_sign, fa_overflow,
      input  rsp_valid, rsp_id, rsp_sum, rsp_flags,
      output rsp_ready
   );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that gives two requesters access to one shared full_adder.
// It keeps one operation in flight and captures the adder result after ADD_LAT cycles of settling.
module adder_arbiter #(
   parameter int ADD_LAT = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   adder_arbiter_if.slave bus,
   output logic           busy,
   output logic [1:0]     state_dbg
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] CNT_INIT = 2'(ADD_LAT - 1);

   state_t     state;
   logic [3:0] op_a;
   logic [3:0] op_b;
   logic [1:0] cnt;
   logic       last_grant;
   logic       rsp_valid_q;
   logic       rsp_id_q;
   logic [7:0] rsp_sum_q;
   logic [4:0] rsp_flags_q;
   logic       grant0;
   logic       grant1;
   logic       take0;
   logic       take1;

   // When both requesters are valid, the one that was not served last wins.
   // Readies are gated by rst_n so that they stay low throughout reset.
   always_comb begin
      grant0 = bus.req0_valid & (~bus.req1_valid | last_grant);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant);
      take0  = rst_n & (state == IDLE) & grant0;
      take1  = rst_n & (state == IDLE) & grant1;
   end

   assign bus.req0_ready = take0;
   assign bus.req1_ready = take1;
   assign bus.fa_a       = op_a;
   assign bus.fa_b       = op_b;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.rsp_sum    = rsp_sum_q;
   assign bus.rsp_flags  = rsp_flags_q;
   assign busy           = (state != IDLE);
   assign state_dbg      = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         op_a        <= 4'd0;
         op_b        <= 4'd0;
         cnt         <= 2'd0;
         last_grant  <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_sum_q   <= 8'd0;
         rsp_flags_q <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               if (take0 | take1) begin
                  op_a       <= take1 ? bus.req1_a : bus.req0_a;
                  op_b       <= take1 ? bus.req1_b : bus.req0_b;
                  rsp_id_q   <= take1;
                  last_grant <= take1;
                  cnt        <= CNT_INIT;
                  state      <= EXEC;
               end
            end
            EXEC: begin
               // The adder output is sampled only after it has had ADD_LAT cycles to settle.
               if (cnt == 2'd0) begin
                  rsp_sum_q   <= bus.fa_out;
                  rsp_flags_q <= {bus.fa_carry, bus.fa_zero, bus.fa_parity, bus.fa_sign, bus.fa_overflow};
                  rsp_valid_q <= 1'b1;
                  state       <= RESP;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
